// File: rtl/fd_opamp_pkg.sv
// Shared types and constants for the fully-differential opamp sequencer.
package fd_opamp_pkg;

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_BIAS  = 3'd1,
    S_CMFB  = 3'd2,
    S_RUN   = 3'd3,
    S_BRK_A = 3'd4,
    S_AZ    = 3'd5,
    S_BRK_B = 3'd6,
    S_SHDN  = 3'd7
  } state_e;

  localparam logic [1:0] ADDR_TRIM   = 2'd0;
  localparam logic [1:0] ADDR_GAIN   = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int unsigned CTRL_SHDN  = 0;
  localparam int unsigned CTRL_AZ_EN = 1;

endpackage

// File: rtl/fd_opamp_cfg_if.sv
// Pin-side configuration interface: write-strobe synchroniser, shadow and
// ctrl registers, pending-commit flag and registered readback.
module fd_opamp_cfg_if
  import fd_opamp_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_wr_i,
  input  logic [1:0] cfg_addr_i,
  input  logic [3:0] cfg_data_i,
  input  logic       commit_i,
  input  logic [3:0] trim_i,
  input  logic [3:0] gain_i,
  input  logic       run_i,
  input  logic       bias_en_i,
  output logic [3:0] shadow_trim_o,
  output logic [3:0] shadow_gain_o,
  output logic       shdn_o,
  output logic       az_en_o,
  output logic       pend_o,
  output logic [3:0] rd_data_o
);

  logic [2:0] sync_q;
  logic       wr_pulse;
  logic [3:0] shadow_trim_q;
  logic [3:0] shadow_gain_q;
  logic [1:0] ctrl_q;
  logic       pend_q;
  logic [3:0] rd_data_q;
  logic [3:0] rd_data_d;

  // Two-flop synchroniser plus a third flop for rising-edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[1:0], cfg_wr_i};
  end

  assign wr_pulse = sync_q[1] & ~sync_q[2];

  // Shadow/ctrl writes; a new trim/gain write keeps pend set even if a
  // commit of the older shadow value happens in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_trim_q <= '0;
      shadow_gain_q <= '0;
      ctrl_q        <= '0;
      pend_q        <= 1'b0;
    end else begin
      if (wr_pulse) begin
        unique case (cfg_addr_i)
          ADDR_TRIM: shadow_trim_q <= cfg_data_i;
          ADDR_GAIN: shadow_gain_q <= cfg_data_i;
          ADDR_CTRL: ctrl_q        <= cfg_data_i[1:0];
          default:   ;
        endcase
      end
      if (wr_pulse && (cfg_addr_i == ADDR_TRIM || cfg_addr_i == ADDR_GAIN))
        pend_q <= 1'b1;
      else if (commit_i)
        pend_q <= 1'b0;
    end
  end

  // Readback mux over committed values.
  always_comb begin
    rd_data_d = '0;
    unique case (cfg_addr_i)
      ADDR_TRIM:   rd_data_d = trim_i;
      ADDR_GAIN:   rd_data_d = gain_i;
      ADDR_CTRL:   rd_data_d = {2'b00, ctrl_q};
      ADDR_STATUS: rd_data_d = {1'b0, pend_q, run_i, bias_en_i};
      default:     rd_data_d = '0;
    endcase
  end

  // Registered readback.
  always_ff @(posedge clk) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;
  end

  assign shadow_trim_o = shadow_trim_q;
  assign shadow_gain_o = shadow_gain_q;
  assign shdn_o        = ctrl_q[CTRL_SHDN];
  assign az_en_o       = ctrl_q[CTRL_AZ_EN];
  assign pend_o        = pend_q;
  assign rd_data_o     = rd_data_q;

endmodule

// File: rtl/fd_opamp_seq_ctrl.sv
// Power-up sequencer, auto-zero scheduler and trim/gain commit for the
// fully-differential opamp macro.
module fd_opamp_seq_ctrl
  import fd_opamp_pkg::*;
#(
  parameter int unsigned T_BIAS    = 64,
  parameter int unsigned T_CMFB    = 32,
  parameter int unsigned NOV       = 2,
  parameter int unsigned AZ_LEN    = 16,
  parameter int unsigned AZ_PERIOD = 1024,
  parameter int unsigned CW        = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       cfg_wr,
  input  logic [1:0] cfg_addr,
  input  logic [3:0] cfg_data,
  output logic [3:0] rd_data,
  output logic       bias_en,
  output logic       cmfb_en,
  output logic       out_en,
  output logic       phi1,
  output logic       phi2,
  output logic [3:0] trim,
  output logic [3:0] gain,
  output logic       ready
);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           az_pass_q, az_pass_d;
  logic           cmfb_hold_q;
  logic [3:0]     trim_q, gain_q;
  logic           cnt_zero, shutdown, commit;
  logic           shdn, az_en, pend;
  logic [3:0]     shadow_trim, shadow_gain;

  function automatic logic [CW-1:0] reload(input state_e s);
    unique case (s)
      S_BIAS:          return CW'(T_BIAS - 1);
      S_CMFB:          return CW'(T_CMFB - 1);
      S_RUN:           return CW'(AZ_PERIOD - 1);
      S_BRK_A, S_BRK_B: return CW'(NOV - 1);
      S_AZ:            return CW'(AZ_LEN - 1);
      default:         return '0;
    endcase
  endfunction

  fd_opamp_cfg_if u_cfg (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_wr_i      (cfg_wr),
    .cfg_addr_i    (cfg_addr),
    .cfg_data_i    (cfg_data),
    .commit_i      (commit),
    .trim_i        (trim_q),
    .gain_i        (gain_q),
    .run_i         (state_q == S_RUN),
    .bias_en_i     (bias_en),
    .shadow_trim_o (shadow_trim),
    .shadow_gain_o (shadow_gain),
    .shdn_o        (shdn),
    .az_en_o       (az_en),
    .pend_o        (pend),
    .rd_data_o     (rd_data)
  );

  assign cnt_zero = (cnt_q == '0);
  assign shutdown = ~ena | shdn;

  // Next state, counter reload and auto-zero pass memory.
  always_comb begin
    state_d   = state_q;
    az_pass_d = az_pass_q;
    unique case (state_q)
      S_OFF:   if (ena && !shdn) state_d = S_BIAS;
      S_BIAS:  if (shutdown) state_d = S_SHDN; else if (cnt_zero) state_d = S_CMFB;
      S_CMFB:  if (shutdown) state_d = S_SHDN; else if (cnt_zero) state_d = S_RUN;
      S_RUN: begin
        if (shutdown) state_d = S_SHDN;
        else if ((az_en && cnt_zero) || pend) begin
          state_d   = S_BRK_A;
          az_pass_d = az_en & cnt_zero;
        end
      end
      S_BRK_A: if (shutdown) state_d = S_SHDN;
               else if (cnt_zero) state_d = az_pass_q ? S_AZ : S_BRK_B;
      S_AZ:    if (shutdown) state_d = S_SHDN; else if (cnt_zero) state_d = S_BRK_B;
      S_BRK_B: if (shutdown) state_d = S_SHDN; else if (cnt_zero) state_d = S_RUN;
      S_SHDN:  state_d = S_OFF;
      default: state_d = S_OFF;
    endcase
    if (state_d != state_q) cnt_d = reload(state_d);
    else if (!cnt_zero)     cnt_d = cnt_q - 1'b1;
    else                    cnt_d = cnt_q;
  end

  // Moore outputs; SHDN keeps bias and the previous cmfb level for one cycle
  // so switches open before the amplifier loses bias.
  always_comb begin
    bias_en = 1'b0;
    cmfb_en = 1'b0;
    phi1    = 1'b0;
    phi2    = 1'b0;
    ready   = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      S_OFF:   commit = pend;
      S_BIAS:  begin bias_en = 1'b1; commit = pend; end
      S_CMFB:  begin bias_en = 1'b1; cmfb_en = 1'b1; commit = pend; end
      S_RUN:   begin bias_en = 1'b1; cmfb_en = 1'b1; phi2 = 1'b1; ready = 1'b1; end
      S_BRK_A, S_BRK_B: begin bias_en = 1'b1; cmfb_en = 1'b1; commit = pend; end
      S_AZ:    begin bias_en = 1'b1; cmfb_en = 1'b1; phi1 = 1'b1; end
      S_SHDN:  begin bias_en = 1'b1; cmfb_en = cmfb_hold_q; end
      default: ;
    endcase
    out_en = phi2;
  end

  // State, counter and committed trim/gain registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_OFF;
      cnt_q       <= '0;
      az_pass_q   <= 1'b0;
      cmfb_hold_q <= 1'b0;
      trim_q      <= '0;
      gain_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      az_pass_q   <= az_pass_d;
      cmfb_hold_q <= cmfb_en;
      if (commit) begin
        trim_q <= shadow_trim;
        gain_q <= shadow_gain;
      end
    end
  end

  assign trim = trim_q;
  assign gain = gain_q;

endmodule

// File: tb/tb_fd_opamp_seq_ctrl.sv
// Directed bench for fd_opamp_seq_ctrl: reset, register access, power-up,
// reconfiguration, auto-zero, shutdown, collision and a random soak with a
// continuous phase-overlap monitor.
module tb_fd_opamp_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, ena, cfg_wr;
  logic [1:0] cfg_addr;
  logic [3:0] cfg_data;
  logic [3:0] rd_data, trim, gain;
  logic       bias_en, cmfb_en, out_en, phi1, phi2, ready;

  int n_tests  = 0;
  int n_failed = 0;

  fd_opamp_seq_ctrl #(
    .T_BIAS(64), .T_CMFB(32), .NOV(2), .AZ_LEN(16), .AZ_PERIOD(1024), .CW(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .rd_data(rd_data), .bias_en(bias_en), .cmfb_en(cmfb_en),
    .out_en(out_en), .phi1(phi1), .phi2(phi2), .trim(trim), .gain(gain), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Returns just after the edge on which the shadow/ctrl register is written.
  task automatic cfg_write(input logic [1:0] a, input logic [3:0] d);
    cfg_addr = a; cfg_data = d; cfg_wr = 1'b1;
    tick(3);
    cfg_wr = 1'b0;
  endtask

  // Phase-overlap and dead-time monitor.
  int last_on = 0;
  int zeros   = 0;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if ((phi1 & phi2) !== 1'b0) begin
        n_failed++; $display("FAIL overlap: phi1=%b phi2=%b required not both 1", phi1, phi2);
      end
      if (out_en !== phi2) begin
        n_failed++; $display("FAIL out_en_eq_phi2: out_en=%b required %b", out_en, phi2);
      end
      if (phi1 === 1'b1) begin
        if (last_on == 2 && zeros < 2) begin
          n_failed++; $display("FAIL nov_gap: %0d zero cycles before phi1, required >=2", zeros);
        end
        last_on = 1; zeros = 0;
      end else if (phi2 === 1'b1) begin
        if (last_on == 1 && zeros < 2) begin
          n_failed++; $display("FAIL nov_gap: %0d zero cycles before phi2, required >=2", zeros);
        end
        last_on = 2; zeros = 0;
      end else begin
        zeros++;
      end
    end
  end

  task automatic test_reset;
    rst_n = 1'b0; ena = 1'b0; cfg_wr = 1'b0; cfg_addr = 2'd0; cfg_data = 4'd0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    n_tests++;
    if ({bias_en, cmfb_en, out_en, phi1, phi2, ready, trim, gain, rd_data} !== 18'd0) begin
      n_failed++;
      $display("FAIL reset_outputs: got %b required all zero",
               {bias_en, cmfb_en, out_en, phi1, phi2, ready, trim, gain, rd_data});
    end
  endtask

  task automatic test_regs;
    cfg_write(2'd2, 4'b1100); tick(3);
    cfg_addr = 2'd2; tick(1);
    n_tests++;
    if (rd_data !== 4'b0000) begin n_failed++; $display("FAIL ctrl_reserved: got %h required 0", rd_data); end
    cfg_write(2'd3, 4'hF); tick(3);
    cfg_addr = 2'd3; tick(1);
    n_tests++;
    if (rd_data !== 4'b0000) begin n_failed++; $display("FAIL status_ro: got %h required 0", rd_data); end
    cfg_write(2'd0, 4'd7);
    n_tests++;
    if (trim !== 4'd0) begin n_failed++; $display("FAIL trim_latency: got %h required 0", trim); end
    tick(1);
    n_tests++;
    if (trim !== 4'd7) begin n_failed++; $display("FAIL trim_commit_off: got %h required 7", trim); end
    tick(1);
    n_tests++;
    if (rd_data !== 4'd7) begin n_failed++; $display("FAIL trim_readback: got %h required 7", rd_data); end
    tick(2);
    cfg_addr = 2'd3; tick(1);
    n_tests++;
    if (rd_data !== 4'b0000) begin n_failed++; $display("FAIL pend_clear_off: got %h required 0", rd_data); end
  endtask

  task automatic test_powerup;
    bit bad_phi1 = 0;
    ena = 1'b1;
    tick(1);
    n_tests++;
    if ({bias_en, cmfb_en} !== 2'b10) begin n_failed++; $display("FAIL pu_bias: got %b required 10", {bias_en, cmfb_en}); end
    for (int i = 0; i < 63; i++) begin tick(1); if (phi1 !== 1'b0) bad_phi1 = 1; end
    n_tests++;
    if ({bias_en, cmfb_en} !== 2'b10) begin n_failed++; $display("FAIL pu_cmfb_early: got %b required 10", {bias_en, cmfb_en}); end
    tick(1);
    n_tests++;
    if ({bias_en, cmfb_en, phi2} !== 3'b110) begin n_failed++; $display("FAIL pu_cmfb: got %b required 110", {bias_en, cmfb_en, phi2}); end
    for (int i = 0; i < 31; i++) begin tick(1); if (phi1 !== 1'b0) bad_phi1 = 1; end
    n_tests++;
    if ({phi2, ready} !== 2'b00) begin n_failed++; $display("FAIL pu_run_early: got %b required 00", {phi2, ready}); end
    tick(1);
    n_tests++;
    if ({phi2, out_en, ready, phi1} !== 4'b1110) begin n_failed++; $display("FAIL pu_run: got %b required 1110", {phi2, out_en, ready, phi1}); end
    n_tests++;
    if (bad_phi1) begin n_failed++; $display("FAIL pu_phi1: got phi1=1 during power-up required 0"); end
  endtask

  task automatic test_reconfig;
    cfg_write(2'd1, 4'hA);
    n_tests++;
    if ({phi2, gain} !== {1'b1, 4'h0}) begin n_failed++; $display("FAIL rc_pre: got phi2=%b gain=%h required 1,0", phi2, gain); end
    for (int i = 0; i < 4; i++) begin
      tick(1);
      n_tests++;
      if ({phi1, phi2, ready} !== 3'b000) begin n_failed++; $display("FAIL rc_break%0d: got %b required 000", i, {phi1, phi2, ready}); end
      if (i == 1) begin
        n_tests++;
        if (gain !== 4'hA) begin n_failed++; $display("FAIL rc_gain_commit: got %h required A", gain); end
      end
    end
    tick(1);
    n_tests++;
    if ({phi2, ready} !== 2'b11) begin n_failed++; $display("FAIL rc_return: got %b required 11", {phi2, ready}); end
    cfg_addr = 2'd3; tick(1);
    n_tests++;
    if (rd_data !== 4'b0011) begin n_failed++; $display("FAIL rc_status: got %b required 0011", rd_data); end
    cfg_addr = 2'd1; tick(1);
    n_tests++;
    if (rd_data !== 4'hA) begin n_failed++; $display("FAIL rc_gain_rd: got %h required A", rd_data); end
  endtask

  task automatic test_autozero;
    int n = 0;
    cfg_write(2'd2, 4'b0010);
    while (phi2 === 1'b1 && n < 1100) begin tick(1); n++; end
    n_tests++;
    if (phi2 !== 1'b0) begin n_failed++; $display("FAIL az_timeout: phi2=%b required 0 within 1100 cycles", phi2); end
    for (int i = 0; i <= 20; i++) begin
      logic [1:0] exp;
      if (i > 0) tick(1);
      exp = {(i >= 2 && i < 18), (i == 20)};
      n_tests++;
      if ({phi1, phi2} !== exp) begin n_failed++; $display("FAIL az_seq[%0d]: got %b required %b", i, {phi1, phi2}, exp); end
    end
    n = 0;
    while (phi2 === 1'b1 && n < 1100) begin n++; tick(1); end
    n_tests++;
    if (n != 1024) begin n_failed++; $display("FAIL az_period: got %0d required 1024", n); end
  endtask

  task automatic test_shutdown_mid_az;
    int n = 0;
    while (phi1 !== 1'b1 && n < 10) begin tick(1); n++; end
    cfg_write(2'd2, 4'b0011);
    n_tests++;
    if (phi1 !== 1'b1) begin n_failed++; $display("FAIL sd_pre: phi1=%b required 1", phi1); end
    tick(1);
    n_tests++;
    if ({phi1, phi2, out_en, bias_en, cmfb_en} !== 5'b00011) begin
      n_failed++; $display("FAIL sd_shdn: got %b required 00011", {phi1, phi2, out_en, bias_en, cmfb_en});
    end
    tick(1);
    n_tests++;
    if ({bias_en, cmfb_en, ready} !== 3'b000) begin n_failed++; $display("FAIL sd_off: got %b required 000", {bias_en, cmfb_en, ready}); end
    tick(5);
    cfg_addr = 2'd3; tick(1);
    n_tests++;
    if ({rd_data, bias_en} !== 5'b00000) begin n_failed++; $display("FAIL sd_stay_off: got %b required 00000", {rd_data, bias_en}); end
  endtask

  task automatic test_collision;
    int n = 0;
    cfg_write(2'd2, 4'b0010);
    while (ready !== 1'b1 && n < 200) begin tick(1); n++; end
    n_tests++;
    if (ready !== 1'b1) begin n_failed++; $display("FAIL col_timeout: ready=%b required 1", ready); end
    tick(1020);
    cfg_write(2'd0, 4'd5);
    n_tests++;
    if ({ready, trim} !== {1'b1, 4'd7}) begin n_failed++; $display("FAIL col_pre: got ready=%b trim=%h required 1,7", ready, trim); end
    for (int i = 0; i <= 20; i++) begin
      logic [1:0] exp;
      tick(1);
      exp = {(i >= 2 && i < 18), (i == 20)};
      n_tests++;
      if ({phi1, phi2} !== exp) begin n_failed++; $display("FAIL col_seq[%0d]: got %b required %b", i, {phi1, phi2}, exp); end
      if (i == 1) begin
        n_tests++;
        if (trim !== 4'd5) begin n_failed++; $display("FAIL col_trim: got %h required 5", trim); end
      end
    end
    n = 0;
    for (int i = 0; i < 30; i++) begin tick(1); if (phi2 !== 1'b1) n++; end
    n_tests++;
    if (n != 0) begin n_failed++; $display("FAIL col_single_pass: got %0d low cycles required 0", n); end
    cfg_addr = 2'd3; tick(1);
    n_tests++;
    if (rd_data !== 4'b0011) begin n_failed++; $display("FAIL col_status: got %b required 0011", rd_data); end
  endtask

  task automatic test_write_during_az;
    int n = 0;
    while (phi1 !== 1'b1 && n < 1100) begin tick(1); n++; end
    cfg_write(2'd1, 4'd3);
    n_tests++;
    if ({phi1, gain} !== {1'b1, 4'hA}) begin n_failed++; $display("FAIL waz_hold: got phi1=%b gain=%h required 1,A", phi1, gain); end
    n = 0;
    while (phi2 !== 1'b1 && n < 30) begin tick(1); n++; end
    n_tests++;
    if ({phi2, gain} !== {1'b1, 4'd3}) begin n_failed++; $display("FAIL waz_commit: got phi2=%b gain=%h required 1,3", phi2, gain); end
    n = 0;
    for (int i = 0; i < 20; i++) begin tick(1); if (phi2 !== 1'b1) n++; end
    n_tests++;
    if (n != 0) begin n_failed++; $display("FAIL waz_no_repass: got %0d low cycles required 0", n); end
  endtask

  task automatic test_random;
    for (int k = 0; k < 1000; k++) begin
      logic [1:0] a;
      logic [3:0] d;
      a = 2'($urandom_range(0, 3));
      d = 4'($urandom);
      if (a == 2'd2) d = {2'b00, 1'b1, ($urandom_range(0, 7) == 0)};
      cfg_write(a, d);
      if ($urandom_range(0, 19) == 0) ena = ~ena;
      tick(3 + $urandom_range(0, 30));
    end
    ena = 1'b1;
    tick(10);
  endtask

  initial begin
    test_reset();
    test_regs();
    test_powerup();
    test_reconfig();
    test_autozero();
    test_shutdown_mid_az();
    test_collision();
    test_write_during_az();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
